nes_gamepad_reader: RTL and testbench
=====================================

# nes_gamepad_reader

Initiator side of the NES gamepad serial interface: drives the controller's latch and clock lines, shifts in the 8 button bits, and presents them as a registered, active-high parallel vector with a one-cycle `valid` strobe. Sits between the gamepad pins and the per-button edge and pulse logic in the TinyTapeStation input path. One read runs per `poll` request, typically issued once per video frame.

## Interface
- `LATCH_CYCLES`, default 300: `nes_latch` high time in clk cycles (12 µs at 25 MHz); range 1..65535.
- `HALF_PERIOD_CYCLES`, default 150: duration of each `nes_clk` low phase and each high phase in clk cycles (6 µs); range 4..65535.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `poll`  in  1  start request; sampled on posedge, ignored while `busy`=1.
- `nes_data`  in  1  controller serial data, active-low (0 = pressed); asynchronous to clk.
- `nes_latch`  out  1  controller latch, active-high.
- `nes_clk`  out  1  controller shift clock; idles low, controller shifts on its rising edge.
- `buttons`  out  8  active-high button state: [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
- `valid`  out  1  one-cycle pulse: a read completed.
- `busy`  out  1  read in progress.

## Operation
- `nes_data` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- FSM states:
  - IDLE: `poll`=1 moves to LATCH.
  - LATCH: `nes_latch`=1 for LATCH_CYCLES, then moves to LOW with bit index 0.
  - LOW: `nes_clk`=0 for HALF_PERIOD_CYCLES. On its last cycle, shift register bit[index] <= ~sync_data.
    - index < 7: moves to HIGH.
    - index = 7: moves to DONE.
  - HIGH: `nes_clk`=1 for HALF_PERIOD_CYCLES, then index+1 and back to LOW.
  - DONE: one cycle. Sets `buttons` <= shift register and `valid`=1, then returns to IDLE.
- Exactly 7 `nes_clk` pulses per read. Bit 0 (A) is valid immediately after the latch falls.
- Phase counter: 16-bit down-counter, loaded with (N−1) on state entry; the state exits on the cycle the counter reads 0. Bit index: 3 bits.
- `busy`=1 in LATCH, LOW, HIGH; 0 in IDLE and DONE.
- `poll` in DONE is ignored; the earliest new accept is the first IDLE cycle.
- `buttons` holds its value between reads and changes only in the DONE cycle.

## Timing
- Reset values (async assert, all outputs): `nes_latch`=0, `nes_clk`=0, `buttons`=8'h00, `valid`=0, `busy`=0, FSM=IDLE, synchronizer flops=1 (released).
- Cycle numbering: cycle 1 is the first cycle after the posedge that samples `poll`=1.
  - `nes_latch` high: cycles 1..LATCH_CYCLES.
  - `busy` high: cycles 1..LATCH_CYCLES+15·HALF_PERIOD_CYCLES.
  - `valid` high and new `buttons`: cycle T = LATCH_CYCLES+15·HALF_PERIOD_CYCLES+1.
  - Defaults: T = 2551 (102 µs).
- Synchronizer latency is 2 cycles. With HALF_PERIOD_CYCLES ≥ 4, data shifted on a `nes_clk` rise is settled before the next sample.
- Reset mid-read: all outputs go to their reset values immediately and the partial frame is discarded.
- `poll` held high continuously: back-to-back reads with one IDLE cycle between DONE and the next LATCH.

## Configuration
- `NES_DEBOUNCE_EN` defined:
  - A second 8-bit register holds the previous raw frame.
  - In DONE, `buttons` updates only if the raw frame equals the previous raw frame; the previous-frame register updates on every DONE.
  - `valid` still pulses on every completed read.
  - Previous-frame register resets to 8'h00.
- `NES_DEBOUNCE_EN` undefined: `buttons` <= raw frame on every DONE.

## Test plan
Bench parameters for all scenarios: LATCH_CYCLES=8, HALF_PERIOD_CYCLES=4, so T=69.
- Reset → all outputs 0 while `rst_n`=0; `poll` held low → `nes_latch` and `nes_clk` stay 0 indefinitely.
- Single `poll`; controller model returns 8'b0101_1010 (pressed pattern) → `nes_latch` high in cycles 1..8, exactly 7 `nes_clk` pulses, `valid` pulses at cycle 69 only, `buttons`=8'h5A, `busy` low at cycle 69.
- Controller model returns all released (`nes_data`=1) → `buttons`=8'h00. All pressed → 8'hFF.
- `poll` re-pulsed at cycles 5 and 40 → ignored; exactly one `valid` occurs.
- `rst_n` asserted at cycle 30 of a read → outputs immediately return to reset values and no `valid` occurs. The next `poll` completes normally with correct data.
- With `NES_DEBOUNCE_EN`: frames 8'h01, 8'h03, 8'h03 → `buttons` is 8'h00, 8'h00, 8'h03 after each `valid`. Without the macro, `buttons` is 8'h01, 8'h03, 8'h03.

Source files
------------

// File: rtl/nes_gamepad_reader_if.sv
// Host-side handshake bundle for nes_gamepad_reader.
//   poll    : start request from the host (master -> reader)
//   buttons : active-high button vector, [0]=A .. [7]=Right (reader -> master)
//   valid   : one-cycle pulse marking a completed read (reader -> master)
//   busy    : a read is in progress (reader -> master)
interface nes_gamepad_reader_if;
  logic       poll;
  logic [7:0] buttons;
  logic       valid;
  logic       busy;

  modport master (output poll, input buttons, input valid, input busy);
  modport slave  (input poll, output buttons, output valid, output busy);
endinterface

// File: rtl/nes_gamepad_reader.sv
// NES gamepad reader: initiator of the controller's serial protocol.
// Pulses the latch line, then clocks out the 8 button bits (A first) with
// seven nes_clk pulses, and publishes the frame as an active-high vector
// together with a one-cycle valid strobe.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst_n     asynchronous active-low reset
//   nes_data  controller serial data, active-low, asynchronous to clk
//   nes_latch controller latch (active-high)
//   nes_clk   controller shift clock, idles low
//   host      nes_gamepad_reader_if.slave: poll in; buttons, valid, busy out
//
// Parameters:
//   LATCH_CYCLES        latch high time in clk cycles (1..65535)
//   HALF_PERIOD_CYCLES  nes_clk low / high phase length in clk cycles (4..65535)
//
// Build option: define NES_DEBOUNCE_EN to publish a frame only when it
// matches the previous raw frame (valid still pulses on every read).
module nes_gamepad_reader #(
  parameter int LATCH_CYCLES       = 300,
  parameter int HALF_PERIOD_CYCLES = 150
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   nes_data,
  output logic                   nes_latch,
  output logic                   nes_clk,
  nes_gamepad_reader_if.slave    host
);

  localparam logic [15:0] LATCH_M1 = 16'(LATCH_CYCLES - 1);
  localparam logic [15:0] HALF_M1  = 16'(HALF_PERIOD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [2:0]  idx, idx_next;
  logic [7:0]  shreg, shreg_next;
  logic        data_meta_p0, data_sync_p1;
  logic [7:0]  buttons_q;
  logic        valid_q;
  logic        busy_q;
`ifdef NES_DEBOUNCE_EN
  logic [7:0]  prev_frame;
`endif

  // Two-flop synchronizer; idles at 1 (released) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_meta_p0 <= 1'b1;
      data_sync_p1 <= 1'b1;
    end else begin
      data_meta_p0 <= nes_data;
      data_sync_p1 <= data_meta_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 16'd0;
      idx   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  // Each timed state loads cnt with N-1 on entry and leaves when it hits 0,
  // so it lasts exactly N cycles.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shreg_next = shreg;
    unique case (state)
      IDLE: begin
        if (host.poll) begin
          state_next = LATCH;
          cnt_next   = LATCH_M1;
        end
      end
      LATCH: begin
        if (cnt == 16'd0) begin
          state_next = LOW;
          cnt_next   = HALF_M1;
          idx_next   = 3'd0;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      LOW: begin
        if (cnt == 16'd0) begin
          // Sample at the very end of the low phase, when the bit driven
          // after the previous rise has had the longest time to settle.
          shreg_next[idx] = ~data_sync_p1;
          cnt_next        = HALF_M1;
          state_next      = (idx == 3'd7) ? DONE : HIGH;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      HIGH: begin
        if (cnt == 16'd0) begin
          state_next = LOW;
          cnt_next   = HALF_M1;
          idx_next   = idx + 3'd1;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Shift register holds no state across reads that matters before it is
  // fully rewritten, so it carries no reset.
  always_ff @(posedge clk) begin
    shreg <= shreg_next;
  end

  // Outputs are registered from the next state so the pins are glitch-free
  // and line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nes_latch <= 1'b0;
      nes_clk   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      buttons_q <= 8'h00;
`ifdef NES_DEBOUNCE_EN
      prev_frame <= 8'h00;
`endif
    end else begin
      nes_latch <= (state_next == LATCH);
      nes_clk   <= (state_next == HIGH);
      valid_q   <= (state_next == DONE);
      busy_q    <= (state_next == LATCH) || (state_next == LOW) ||
                   (state_next == HIGH);
      if (state_next == DONE) begin
`ifdef NES_DEBOUNCE_EN
        if (shreg_next == prev_frame) begin
          buttons_q <= shreg_next;
        end
        prev_frame <= shreg_next;
`else
        buttons_q <= shreg_next;
`endif
      end
    end
  end

  assign host.buttons = buttons_q;
  assign host.valid   = valid_q;
  assign host.busy    = busy_q;

endmodule

// File: tb/tb_nes_gamepad_reader.sv
// Self-checking bench for nes_gamepad_reader with LATCH_CYCLES=8 and
// HALF_PERIOD_CYCLES=4 (valid expected at cycle 69). A behavioural
// controller model serves a chosen pressed pattern; expected buttons come
// from the frame/debounce rules applied to the pattern sequence.
module tb_nes_gamepad_reader;
  localparam int L = 8;
  localparam int H = 4;
  localparam int T = L + 15 * H + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic nes_data;
  logic nes_latch;
  logic nes_clk;

  nes_gamepad_reader_if bus ();

  nes_gamepad_reader #(
    .LATCH_CYCLES      (L),
    .HALF_PERIOD_CYCLES(H)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .nes_data (nes_data),
    .nes_latch(nes_latch),
    .nes_clk  (nes_clk),
    .host     (bus.slave)
  );

  always #5 clk = ~clk;

  // Controller: parallel-load while latched, shift on each nes_clk rise.
  logic [7:0] pressed = 8'h00;
  logic [7:0] pad_sh = 8'hFF;
  logic       pad_prev_clk = 1'b0;
  always @(negedge clk) begin
    if (nes_latch) pad_sh = ~pressed;
    else if (nes_clk && !pad_prev_clk) pad_sh = {1'b1, pad_sh[7:1]};
    pad_prev_clk = nes_clk;
  end
  assign nes_data = pad_sh[0];

  int checks = 0;
  int errors = 0;

  // Reference state: what buttons should show, and the last raw frame.
  logic [7:0] model_buttons = 8'h00;
  logic [7:0] model_prev = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_frame(input logic [7:0] raw);
`ifdef NES_DEBOUNCE_EN
    if (raw == model_prev) model_buttons = raw;
`else
    model_buttons = raw;
`endif
    model_prev = raw;
  endfunction

  task automatic model_reset();
    model_buttons = 8'h00;
    model_prev    = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_latch"}, 32'(nes_latch), 0);
    check({tag, "_nclk"}, 32'(nes_clk), 0);
    check({tag, "_valid"}, 32'(bus.valid), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_buttons"}, 32'(bus.buttons), 0);
  endtask

  // One full read; optional poll re-pulses mid-read, optional poll hold
  // to check the back-to-back restart.
  task automatic do_read(input logic [7:0] pat, input bit repulse, input bit hold);
    int lat_cnt = 0, lat_last = 0, busy_first = 0, busy_last = 0;
    int rises = 0, vcnt = 0, vat = 0, early = 0;
    logic prev_c = nes_clk;
    logic [7:0] old_btn = model_buttons;
    logic [7:0] btn_t = 8'h00;
    logic lat_t1 = 1'b0, lat_t2 = 1'b0;
    bit got;
    pressed  = pat;
    bus.poll = 1'b1;
    for (int c = 1; c <= T + 2; c++) begin
      @(posedge clk); #1;
      if (!hold) bus.poll = (repulse && (c == 5 || c == 40)) ? 1'b1 : 1'b0;
      if (c <= T) begin
        if (nes_latch) begin lat_cnt++; lat_last = c; end
        if (bus.busy) begin if (busy_first == 0) busy_first = c; busy_last = c; end
        if (nes_clk && !prev_c) rises++;
        if (bus.valid) begin vcnt++; vat = c; end
        if (c < T && bus.buttons !== old_btn) early++;
        if (c == T) btn_t = bus.buttons;
      end
      if (c == T + 1) begin lat_t1 = nes_latch; if (bus.valid) vcnt++; end
      if (c == T + 2) lat_t2 = nes_latch;
      prev_c = nes_clk;
    end
    model_frame(pat);
    check("latch_cycles", lat_cnt, L);
    check("latch_last", lat_last, L);
    check("busy_first", busy_first, 1);
    check("busy_last", busy_last, T - 1);
    check("nes_clk_pulses", rises, 7);
    check("valid_count", vcnt, 1);
    check("valid_cycle", vat, T);
    check("buttons_early_change", early, 0);
    check("buttons", 32'(btn_t), 32'(model_buttons));
    check("latch_after_done", 32'(lat_t1), 0);
    check("restart_latch", 32'(lat_t2), 32'(hold));
    if (hold) begin
      bus.poll = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 3 * T && !got; k++) begin
        @(posedge clk); #1;
        if (bus.valid) got = 1'b1;
      end
      check("b2b_valid_seen", 32'(got), 1);
      model_frame(pat);
      check("b2b_buttons", 32'(bus.buttons), 32'(model_buttons));
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_assert");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int bad;
    logic [7:0] pat;
    logic [7:0] db_exp [3];
    logic [7:0] db_pat [3];
    bus.poll = 1'b0;

    // Reset state.
    #3;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por_hold");
    rst_n = 1'b1;

    // Idle with poll low: pins stay quiet.
    bad = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (nes_latch || nes_clk || bus.busy || bus.valid) bad++;
    end
    check("idle_quiet", bad, 0);

    // Directed patterns.
    do_read(8'h5A, 1'b0, 1'b0);
    do_read(8'h00, 1'b0, 1'b0);
    do_read(8'hFF, 1'b0, 1'b0);
    do_read(8'hFF, 1'b0, 1'b0);

    // Poll re-pulsed mid-read is ignored.
    do_read(8'($urandom), 1'b1, 1'b0);

    // Reset at cycle 30 of a read.
    pressed  = 8'($urandom);
    bus.poll = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      bus.poll = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midread_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    bad = 0;
    repeat (2 * T) begin
      @(posedge clk); #1;
      if (bus.valid || bus.busy) bad++;
    end
    check("no_valid_after_reset", bad, 0);
    pat = 8'($urandom);
    do_read(pat, 1'b0, 1'b0);
    do_read(pat, 1'b0, 1'b0);

    // Frame sequence 01, 03, 03 from a clean reset.
    apply_reset();
    db_pat = '{8'h01, 8'h03, 8'h03};
`ifdef NES_DEBOUNCE_EN
    db_exp = '{8'h00, 8'h00, 8'h03};
`else
    db_exp = '{8'h01, 8'h03, 8'h03};
`endif
    for (int i = 0; i < 3; i++) begin
      do_read(db_pat[i], 1'b0, 1'b0);
      check("seq_buttons", 32'(bus.buttons), 32'(db_exp[i]));
    end

    // Randomized reads, sometimes repeating the previous pattern.
    pat = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 0) pat = 8'($urandom);
      do_read(pat, 1'b0, 1'b0);
    end

    // Poll held high: back-to-back reads.
    do_read(8'($urandom), 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
